// File: rtl/status_shadow_register.sv
// status_shadow_register: live status register with n_to/n_pd power flags and a LIFO shadow stack for interrupt context save/restore.
module status_shadow_register #(
    parameter int SHADOW_DEPTH = 2,
    parameter int RP_WIDTH = 2,
    localparam int STATUS_W = RP_WIDTH + 6,
    localparam int OCC_W = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                status_wr,
    input  logic [STATUS_W-1:0] status_reg_in,
    input  logic [2:0]          flag_wr_mask,
    input  logic [2:0]          flag_in,
    input  logic                clrwdt,
    input  logic                sleep,
    input  logic                wdt_timeout,
    input  logic                ctx_save,
    input  logic                ctx_restore,
    input  logic                err_clr,
    output logic [STATUS_W-1:0] status_reg_out,
    output logic                irp,
    output logic [RP_WIDTH-1:0] rp,
    output logic                n_to,
    output logic                n_pd,
    output logic                z,
    output logic                dc,
    output logic                c,
    output logic                shadow_empty,
    output logic                shadow_full,
    output logic                shadow_overflow,
    output logic                shadow_underflow
);
    logic [STATUS_W-1:0] stack [2**OCC_W];
    logic [OCC_W-1:0]    occ, occ_n;
    logic [STATUS_W-1:0] wr_v, alu_v, top, base, nxt;
    logic [1:0]          pwr;
    logic                only_save, only_restore, push, pop;

    assign only_save    = ctx_save & ~ctx_restore;
    assign only_restore = ctx_restore & ~ctx_save;
    assign push         = only_save & ~shadow_full;
    assign pop          = only_restore & ~shadow_empty;
    assign occ_n        = push ? occ + OCC_W'(1) : pop ? occ - OCC_W'(1) : occ;
    assign top          = stack[occ - OCC_W'(1)];

    // n_to/n_pd are never taken from software writes, the ALU or a pop
    always_comb begin
        wr_v  = status_wr ? status_reg_in : status_reg_out;
        alu_v = {wr_v[STATUS_W-1:3], (flag_wr_mask & flag_in) | (~flag_wr_mask & wr_v[2:0])};
        base  = pop ? top : alu_v;
        pwr   = wdt_timeout ? {1'b0, status_reg_out[3]} :
                sleep       ? 2'b10 :
                clrwdt      ? 2'b11 : status_reg_out[4:3];
        nxt   = {base[STATUS_W-1:5], pwr, base[2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg_out   <= {{(RP_WIDTH + 1){1'b0}}, 5'b11000};
            occ              <= '0;
            shadow_empty     <= 1'b1;
            shadow_full      <= 1'b0;
            shadow_overflow  <= 1'b0;
            shadow_underflow <= 1'b0;
        end else begin
            status_reg_out   <= nxt;
            occ              <= occ_n;
            shadow_empty     <= occ_n == '0;
            shadow_full      <= occ_n == OCC_W'(SHADOW_DEPTH);
            shadow_overflow  <= (only_save & shadow_full) | (shadow_overflow & ~err_clr);
            shadow_underflow <= (only_restore & shadow_empty) | (shadow_underflow & ~err_clr);
        end
    end

    // Entries are not cleared by reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (!rst && push)
            stack[occ] <= status_reg_out;
    end

    assign irp  = status_reg_out[STATUS_W-1];
    assign rp   = status_reg_out[STATUS_W-2:5];
    assign n_to = status_reg_out[4];
    assign n_pd = status_reg_out[3];
    assign z    = status_reg_out[2];
    assign dc   = status_reg_out[1];
    assign c    = status_reg_out[0];
endmodule

// File: tb/tb_status_shadow_register.sv
// tb_status_shadow_register: directed vector table plus hand-written reset sequences for status_shadow_register.
module tb_status_shadow_register;
    logic       clk = 1'b0;
    logic       rst, status_wr, clrwdt, sleep, wdt_timeout, ctx_save, ctx_restore, err_clr;
    logic [7:0] status_reg_in, status_reg_out;
    logic [2:0] flag_wr_mask, flag_in;
    logic       irp, n_to, n_pd, z, dc, c;
    logic [1:0] rp;
    logic       shadow_empty, shadow_full, shadow_overflow, shadow_underflow;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    status_shadow_register dut (
        .clk(clk), .rst(rst), .status_wr(status_wr), .status_reg_in(status_reg_in),
        .flag_wr_mask(flag_wr_mask), .flag_in(flag_in), .clrwdt(clrwdt), .sleep(sleep),
        .wdt_timeout(wdt_timeout), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .err_clr(err_clr), .status_reg_out(status_reg_out), .irp(irp), .rp(rp),
        .n_to(n_to), .n_pd(n_pd), .z(z), .dc(dc), .c(c), .shadow_empty(shadow_empty),
        .shadow_full(shadow_full), .shadow_overflow(shadow_overflow),
        .shadow_underflow(shadow_underflow)
    );

    typedef struct {
        logic       rst, wr;
        logic [7:0] din;
        logic [2:0] mask, fin;
        logic       clr, slp, wdt, sv, rs, ec;
        logic [7:0] exp;
        logic       e, f, o, u;
    } vec_t;

    vec_t vecs [30];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; status_wr = v.wr; status_reg_in = v.din; flag_wr_mask = v.mask;
        flag_in = v.fin; clrwdt = v.clr; sleep = v.slp; wdt_timeout = v.wdt;
        ctx_save = v.sv; ctx_restore = v.rs; err_clr = v.ec;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " status"}, status_reg_out, v.exp);
        chk({tag, " fields"}, {irp, rp, n_to, n_pd, z, dc, c}, v.exp);
        chk({tag, " flags"}, {4'h0, shadow_empty, shadow_full, shadow_overflow, shadow_underflow},
            {4'h0, v.e, v.f, v.o, v.u});
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] d,
                                input logic [2:0] m, input logic [2:0] fi,
                                input logic cl, input logic sl, input logic wd,
                                input logic s, input logic re, input logic ecl,
                                input logic [7:0] x, input logic ee, input logic ff,
                                input logic oo, input logic uu);
        vec_t v;
        v = '{r, w, d, m, fi, cl, sl, wd, s, re, ecl, x, ee, ff, oo, uu};
        return v;
    endfunction

    initial begin
        vec_t v;
        //            rst wr din    mask  fin   clr slp wdt sv rs ec  exp    e  f  o  u
        vecs[0]  = mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'h18, 1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'hFF, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h00, 3'b101, 3'b111, 0, 0, 0, 0, 0, 0, 8'h1D, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 1, 0, 0, 0, 0, 8'h15, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 8'h05, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 8'h1D, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 1, 1, 0, 0, 0, 8'h0D, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 8'h1D, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 8'h45, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'h5D, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h5D, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'hA2, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'hBA, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'hBA, 0, 1, 0, 0);
        vecs[12] = mk(0, 1, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'h18, 0, 1, 0, 0);
        vecs[13] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'hBA, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 1, 0, 0, 1);
        vecs[16] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 8'h5D, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h5D, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h5D, 0, 1, 0, 0);
        vecs[19] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h5D, 0, 1, 1, 0);
        vecs[20] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 1, 8'h5D, 0, 1, 1, 0);
        vecs[21] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 8'h5D, 0, 1, 0, 0);
        vecs[22] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 0, 0, 0, 0);
        vecs[23] = mk(0, 1, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0, 8'h18, 0, 0, 0, 0);
        vecs[24] = mk(0, 1, 8'hFF, 3'b111, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 1, 0, 0, 0);
        vecs[25] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 1, 0, 0, 1);
        vecs[26] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 1, 8'h5D, 1, 0, 0, 1);
        vecs[27] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 8'h5D, 1, 0, 0, 0);
        vecs[28] = mk(0, 1, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h18, 0, 0, 0, 0);
        vecs[29] = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h5D, 1, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // fill the stack and raise overflow, then reset in the middle of a save
        drive(mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 8'h5D, 0, 0, 0, 0));
        drive(mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 1, 0, 1, 0, 0, 8'h55, 0, 1, 0, 0));
        drive(mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 1, 0, 0, 8'h45, 0, 1, 1, 0));
        check_all("pre_rst", mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 8'h45, 0, 1, 1, 0));
        v = mk(1, 1, 8'hFF, 3'b111, 3'b111, 0, 1, 0, 1, 0, 0, 8'h18, 1, 0, 0, 0);
        drive(v);
        check_all("rst_save", v);
        v = mk(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h18, 1, 0, 0, 1);
        drive(v);
        check_all("post_rst_pop", v);
        v = mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 8'h18, 1, 0, 0, 0);
        drive(v);
        check_all("rst_restore", v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
